// File: rtl/led_matrix_scan_ctrl_if.sv
// Pixel-write and bank-swap bus between game logic and the LED matrix
// scan controller.
//
// Signals:
//   wr_en       - pixel write strobe (master -> slave)
//   wr_row      - write row address
//   wr_col      - write column address
//   wr_rgb      - pixel colour {R,G,B}, 1 = lit
//   swap_req    - ask for a bank swap at the next frame boundary
//   swap_ack    - one-cycle pulse when the swap takes effect (slave -> master)
//   frame_start - one-cycle pulse when the scan wraps to row 0 (slave -> master)
interface led_matrix_scan_ctrl_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    logic                      wr_en;
    logic [$clog2(ROWS)-1:0]   wr_row;
    logic [$clog2(COLS)-1:0]   wr_col;
    logic [2:0]                wr_rgb;
    logic                      swap_req;
    logic                      swap_ack;
    logic                      frame_start;

    modport master (
        output wr_en, wr_row, wr_col, wr_rgb, swap_req,
        input  swap_ack, frame_start
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_rgb, swap_req,
        output swap_ack, frame_start
    );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scanning driver for a common-row RGB LED matrix with a double-buffered
// 3-bit-per-pixel frame store. One row is shown per DIV-cycle dwell; the
// first BLANK cycles of each dwell keep the row driver off and the colour
// pins inactive to avoid ghosting. Display and write banks exchange only at
// frame boundaries, on request.
//
// Ports:
//   CLK    - system clock
//   RST    - asynchronous reset, active-high
//   bus    - pixel write / swap handshake (slave side)
//   Data_R - red column drive   (COLS wide, polarity set by ACTIVE_LOW)
//   Data_G - green column drive
//   Data_B - blue column drive
//   COMM   - selected row
//   E      - row driver enable, active-high
module led_matrix_scan_ctrl #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DIV        = 25124,
    parameter int BLANK      = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    led_matrix_scan_ctrl_if.slave    bus,
    output logic [COLS-1:0]          Data_R,
    output logic [COLS-1:0]          Data_G,
    output logic [COLS-1:0]          Data_B,
    output logic [$clog2(ROWS)-1:0]  COMM,
    output logic                     E
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(DIV);

    // XOR mask that turns "lit" bits into pin levels; also the idle pin value.
    localparam logic [COLS-1:0] INACTIVE = (ACTIVE_LOW != 0) ? {COLS{1'b1}} : {COLS{1'b0}};

    logic [2:0]     pix [0:1][0:ROWS-1][0:COLS-1];
    logic           disp_bank;
    logic           wr_bank;
    logic           pending;
    logic [CW-1:0]  cnt;
    logic           wr_ok;
    logic           row_end;
    logic           frame_end;
    logic           swap_now;
    logic [COLS-1:0] row_r;
    logic [COLS-1:0] row_g;
    logic [COLS-1:0] row_b;

    assign wr_bank   = ~disp_bank;
    assign wr_ok     = bus.wr_en && (int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS);
    assign row_end   = (cnt == CW'(DIV - 1));
    assign frame_end = row_end && (COMM == RW'(ROWS - 1));
    assign swap_now  = frame_end && pending;

    // Current display-bank row, as "lit" bits, ready to be latched into the pins.
    always_comb begin
        row_r = '0;
        row_g = '0;
        row_b = '0;
        for (int c = 0; c < COLS; c++) begin
            row_r[c] = pix[disp_bank][COMM][c][2];
            row_g[c] = pix[disp_bank][COMM][c][1];
            row_b[c] = pix[disp_bank][COMM][c][0];
        end
    end

    // Frame store. Writes always target the bank that is not on display as
    // seen before the edge, so a write on the swap edge ends up in the bank
    // that is about to become visible.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        pix[b][r][c] <= 3'b000;
                    end
                end
            end
        end else if (wr_ok) begin
            pix[wr_bank][bus.wr_row][bus.wr_col] <= bus.wr_rgb;
        end
    end

    // Dwell counter, row scan, blanking and bank swap. Pins go inactive on
    // the edge that starts a dwell and take the row contents on the edge that
    // ends the blank window, so a row never changes mid-dwell. A request seen
    // on the boundary cycle of a swap stays pending for the next boundary.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt             <= '0;
            COMM            <= '0;
            E               <= 1'b0;
            Data_R          <= INACTIVE;
            Data_G          <= INACTIVE;
            Data_B          <= INACTIVE;
            disp_bank       <= 1'b0;
            pending         <= 1'b0;
            bus.swap_ack    <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.frame_start <= frame_end;
            bus.swap_ack    <= swap_now;
            pending         <= swap_now ? bus.swap_req : (pending | bus.swap_req);

            if (swap_now) begin
                disp_bank <= ~disp_bank;
            end

            if (row_end) begin
                cnt    <= '0;
                E      <= 1'b0;
                Data_R <= INACTIVE;
                Data_G <= INACTIVE;
                Data_B <= INACTIVE;
                if (frame_end) begin
                    COMM <= '0;
                end else begin
                    COMM <= COMM + 1'b1;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(BLANK - 1)) begin
                    E      <= 1'b1;
                    Data_R <= row_r ^ INACTIVE;
                    Data_G <= row_g ^ INACTIVE;
                    Data_B <= row_b ^ INACTIVE;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Testbench for led_matrix_scan_ctrl with an 8x8 matrix, DIV=10, BLANK=2.
// Two instances share the write bus: one with active-low colour pins and
// one with active-high pins. A time-based reference model predicts every
// output on every cycle; directed table vectors and hand sequences cover
// the write/swap corner cases, followed by random traffic and a mid-row reset.
module tb_led_matrix_scan_ctrl;

    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = ROWS * DIV;

    logic clk;
    logic rst;

    led_matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    led_matrix_scan_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus2 ();

    logic [7:0] data_r, data_g, data_b;
    logic [2:0] comm;
    logic       e;
    logic [7:0] data_r2, data_g2, data_b2;
    logic [2:0] comm2;
    logic       e2;

    assign bus2.wr_en    = bus.wr_en;
    assign bus2.wr_row   = bus.wr_row;
    assign bus2.wr_col   = bus.wr_col;
    assign bus2.wr_rgb   = bus.wr_rgb;
    assign bus2.swap_req = bus.swap_req;

    led_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(1)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus),
        .Data_R(data_r), .Data_G(data_g), .Data_B(data_b),
        .COMM(comm), .E(e)
    );

    led_matrix_scan_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(0)
    ) dut_hi (
        .CLK(clk), .RST(rst), .bus(bus2),
        .Data_R(data_r2), .Data_G(data_g2), .Data_B(data_b2),
        .COMM(comm2), .E(e2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic apply_stimulus(input bit en, input int row, input int col, input logic [2:0] rgb, input bit req);
        bus.wr_en    = en;
        bus.wr_row   = 3'(row);
        bus.wr_col   = 3'(col);
        bus.wr_rgb   = rgb;
        bus.swap_req = req;
    endtask

    // which: 0 = frame_start, 1 = swap_ack, 2 = E high. Returns at the negedge
    // on which the signal is seen; an expired budget counts as a failure.
    task automatic wait_for(input int which, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            @(negedge clk);
            if ((which == 0 && bus.frame_start) || (which == 1 && bus.swap_ack) || (which == 2 && e))
                found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("[TB] FAIL timeout %s: got no event expected event", name);
        end
    endtask

    // Reference model: time since reset decides row, phase and frame
    // boundaries; banks are plain arrays selected by an index.
    logic [2:0] m_mem [0:1][0:ROWS-1][0:COLS-1];
    int         m_t;
    int         m_shown;
    bit         m_pend;
    bit         m_fs;
    bit         m_ack;
    logic [2:0] m_snap [0:COLS-1];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_shown = 0; m_pend = 0; m_fs = 0; m_ack = 0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        m_mem[b][r][c] = 3'b000;
            for (int c = 0; c < COLS; c++) m_snap[c] = 3'b000;
        end else begin
            m_t = m_t + 1;
            if (bus.wr_en && int'(bus.wr_row) < ROWS && int'(bus.wr_col) < COLS)
                m_mem[1 - m_shown][bus.wr_row][bus.wr_col] = bus.wr_rgb;
            m_fs  = (m_t % FRAME == 0);
            m_ack = 1'b0;
            if (m_fs && m_pend) begin
                m_shown = 1 - m_shown;
                m_ack   = 1'b1;
                m_pend  = bus.swap_req;
            end else begin
                m_pend = m_pend || bus.swap_req;
            end
            if (m_t % DIV == BLANK)
                for (int c = 0; c < COLS; c++) m_snap[c] = m_mem[m_shown][(m_t / DIV) % ROWS][c];
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic       x_e;
            logic [2:0] x_comm;
            logic [7:0] lr, lg, lb;
            x_e    = (m_t % DIV) >= BLANK;
            x_comm = 3'((m_t / DIV) % ROWS);
            for (int c = 0; c < COLS; c++) begin
                lr[c] = x_e & m_snap[c][2];
                lg[c] = x_e & m_snap[c][1];
                lb[c] = x_e & m_snap[c][0];
            end
            check_output("model_low",
                {2'b00, e, comm, data_r, data_g, data_b, bus.frame_start, bus.swap_ack},
                {2'b00, x_e, x_comm, ~lr, ~lg, ~lb, m_fs, m_ack});
            check_output("model_high",
                {2'b00, e2, comm2, data_r2, data_g2, data_b2, bus2.frame_start, bus2.swap_ack},
                {2'b00, x_e, x_comm, lr, lg, lb, m_fs, m_ack});
        end
    end

    typedef struct {
        int         row;
        int         col;
        logic [2:0] rgb;
        logic [7:0] pre;
        logic [7:0] exp_r;
        logic [7:0] exp_g;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int n;
        int elow;
        int acks;

        vecs[0] = '{row: 3, col: 0, rgb: 3'b100, pre: 8'hFF, exp_r: 8'hFE, exp_g: 8'hFF, exp_b: 8'hFF};
        vecs[1] = '{row: 6, col: 3, rgb: 3'b111, pre: 8'hFF, exp_r: 8'hF7, exp_g: 8'hF7, exp_b: 8'hF7};
        vecs[2] = '{row: 0, col: 7, rgb: 3'b010, pre: 8'hFF, exp_r: 8'hFF, exp_g: 8'h7F, exp_b: 8'hFF};
        vecs[3] = '{row: 1, col: 4, rgb: 3'b001, pre: 8'hFF, exp_r: 8'hFF, exp_g: 8'hFF, exp_b: 8'hEF};

        rst = 1'b1;
        apply_stimulus(0, 0, 0, 3'b000, 0);
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check_output("reset_E", 32'(e), 32'd0);
        check_output("reset_data", {8'h0, data_r, data_g, data_b}, {8'h0, 24'hFFFFFF});
        check_output("reset_data_high", {8'h0, data_r2, data_g2, data_b2}, 32'h0);
        check_output("reset_comm", 32'(comm), 32'd0);

        // Reset release: this negedge is cycle 0.
        rst = 1'b0;
        check_output("cyc0_E", 32'(e), 32'd0);
        @(negedge clk);
        check_output("cyc1_E", 32'(e), 32'd0);
        check_output("cyc1_comm", 32'(comm), 32'd0);
        @(negedge clk);
        check_output("cyc2_E", 32'(e), 32'd1);
        check_output("cyc2_data", {8'h0, data_r, data_g, data_b}, {8'h0, 24'hFFFFFF});
        repeat (8) @(negedge clk);
        check_output("cyc10_comm", 32'(comm), 32'd1);

        // Frame period and blanking duty.
        wait_for(0, "first_frame_start");
        n = 0;
        elow = 0;
        do begin
            @(negedge clk);
            n++;
            if (!e) elow++;
        end while (!bus.frame_start && n < 3 * FRAME);
        check_output("frame_period", 32'(n), 32'(FRAME));
        check_output("blank_cycles", 32'(elow), 32'(ROWS * BLANK));

        // Table vectors: write, confirm hidden, swap, confirm visible.
        for (int i = 0; i < 4; i++) begin
            wait_for(0, "vec_frame_start");
            apply_stimulus(1, vecs[i].row, vecs[i].col, vecs[i].rgb, 0);
            @(negedge clk);
            apply_stimulus(0, 0, 0, 3'b000, 0);
            repeat (DIV * vecs[i].row + 4) @(negedge clk);
            check_output($sformatf("vec%0d_pre", i), {8'h0, data_r, data_g, data_b},
                         {8'h0, vecs[i].pre, vecs[i].pre, vecs[i].pre});
            apply_stimulus(0, 0, 0, 3'b000, 1);
            @(negedge clk);
            apply_stimulus(0, 0, 0, 3'b000, 0);
            wait_for(1, "vec_swap_ack");
            check_output($sformatf("vec%0d_ack_with_fs", i), 32'(bus.frame_start), 32'd1);
            repeat (DIV * vecs[i].row + 5) @(negedge clk);
            check_output($sformatf("vec%0d_post", i), {8'h0, data_r, data_g, data_b},
                         {8'h0, vecs[i].exp_r, vecs[i].exp_g, vecs[i].exp_b});
        end

        // Three requests in one frame give exactly one swap.
        wait_for(0, "multi_frame_start");
        repeat (5) @(negedge clk);
        apply_stimulus(0, 0, 0, 3'b000, 1); @(negedge clk); apply_stimulus(0, 0, 0, 3'b000, 0);
        repeat (14) @(negedge clk);
        apply_stimulus(0, 0, 0, 3'b000, 1); @(negedge clk); apply_stimulus(0, 0, 0, 3'b000, 0);
        repeat (19) @(negedge clk);
        apply_stimulus(0, 0, 0, 3'b000, 1); @(negedge clk); apply_stimulus(0, 0, 0, 3'b000, 0);
        acks = 0;
        for (int i = 0; i < 2 * FRAME + 40; i++) begin
            @(negedge clk);
            if (bus.swap_ack) acks++;
        end
        check_output("multi_swap_acks", 32'(acks), 32'd1);

        // Write presented in the cycle that ends on the swap edge.
        wait_for(0, "edge_frame_start");
        repeat (10) @(negedge clk);
        apply_stimulus(0, 0, 0, 3'b000, 1); @(negedge clk); apply_stimulus(0, 0, 0, 3'b000, 0);
        repeat (FRAME - 12) @(negedge clk);
        apply_stimulus(1, 5, 7, 3'b011, 0);
        @(negedge clk);
        apply_stimulus(0, 0, 0, 3'b000, 0);
        check_output("edge_swap_ack", 32'(bus.swap_ack), 32'd1);
        repeat (DIV * 5 + 5) @(negedge clk);
        check_output("edge_row5", {8'h0, data_r, data_g, data_b}, {8'h0, 8'hFF, 8'h7F, 8'h7F});

        // Random traffic against the model, including out-of-range-free
        // writes in both banks and occasional swaps.
        for (int i = 0; i < 1500; i++) begin
            apply_stimulus(($urandom % 3) == 0, $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1),
                           3'($urandom), ($urandom % 40) == 0);
            @(negedge clk);
        end
        apply_stimulus(0, 0, 0, 3'b000, 0);

        // Asynchronous reset in the middle of a SHOW window.
        wait_for(2, "show_window");
        #2 rst = 1'b1;
        #1;
        check_output("async_E", 32'(e), 32'd0);
        check_output("async_data", {8'h0, data_r, data_g, data_b}, {8'h0, 24'hFFFFFF});
        check_output("async_data_high", {8'h0, data_r2, data_g2, data_b2}, 32'h0);
        check_output("async_comm", 32'(comm), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Both banks must come back blank: look at one frame, swap, look again.
        repeat (FRAME + 20) @(negedge clk);
        apply_stimulus(0, 0, 0, 3'b000, 1); @(negedge clk); apply_stimulus(0, 0, 0, 3'b000, 0);
        wait_for(1, "post_reset_ack");
        repeat (DIV * 3 + 5) @(negedge clk);
        check_output("post_reset_row3", {8'h0, data_r, data_g, data_b}, {8'h0, 24'hFFFFFF});
        repeat (FRAME) @(negedge clk);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
- Parametrised row-scanning driver for a common-row RGB LED matrix. The default geometry is 8x8.
- Holds a double-buffered frame store with 3-bit colour per pixel and accepts pixel writes from game logic.
- Scans one row per dwell period and blanks at the start of each row to stop ghosting.
- Swaps the display and write banks only at frame boundaries. Drives the Data_R/G/B, COMM and E pins directly.

Parameters:
- ROWS, 8, number of matrix rows; COMM width is $clog2(ROWS).
- COLS, 8, number of columns; this is the width of Data_R, Data_G and Data_B.
- DIV, 25124, CLK cycles per row dwell; must be >= 2.
- BLANK, 16, cycles at the start of each dwell with E=0 and all data inactive; must satisfy 1 <= BLANK < DIV.
- ACTIVE_LOW, 1, colour pins are active-low when 1 and active-high when 0.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- wr_en  in  1  pixel write strobe.
- wr_row  in  $clog2(ROWS)  write row address.
- wr_col  in  $clog2(COLS)  write column address.
- wr_rgb  in  3  pixel colour {R,G,B}; 1 = lit.
- swap_req  in  1  request a bank swap at the next frame boundary.
- swap_ack  out  1  one-cycle pulse on the cycle the swap takes effect.
- frame_start  out  1  one-cycle pulse when the scan wraps to row 0.
- Data_R  out  COLS  red column drive.
- Data_G  out  COLS  green column drive.
- Data_B  out  COLS  blue column drive.
- COMM  out  $clog2(ROWS)  selected row.
- E  out  1  row driver enable, active-high.

Behaviour:
- Reset (asynchronous, immediate):
  - All pixels in both banks are cleared to 0.
  - Display bank = 0, write bank = 1; swap-pending flag cleared.
  - Dwell counter cnt = 0, COMM = 0, E = 0.
  - Data_R, Data_G and Data_B are inactive: all 1s when ACTIVE_LOW, all 0s otherwise.
  - swap_ack = 0, frame_start = 0.
- Dwell counter:
  - cnt counts 0..DIV-1 and advances every cycle.
  - At cnt == DIV-1, cnt returns to 0 and COMM advances; ROWS-1 wraps to 0.
- BLANK phase (cnt < BLANK):
  - E = 0 and all colour pins are inactive.
  - COMM changes only on the edge that enters this phase.
- SHOW phase (cnt >= BLANK):
  - On the edge where cnt becomes BLANK, the outputs register the display-bank row COMM.
  - Data_X[c] = pixel(COMM,c).X, inverted when ACTIVE_LOW.
  - E = 1 on the same edge. The outputs hold until the next BLANK.
- Frame boundary: the edge where COMM goes from ROWS-1 to 0.
  - frame_start pulses on this edge.
  - If swap is pending, the banks exchange on this edge, swap_ack pulses in the same cycle as frame_start, and the pending flag clears.
  - The first frame_start after reset comes at ROWS*DIV cycles.
- swap_req:
  - Sets the pending flag. Extra requests while pending are absorbed, so only one swap and one ack occur.
  - A swap_req on the boundary cycle itself is taken at the next boundary.
- Writes:
  - wr_en writes wr_rgb into the current write bank at (wr_row, wr_col) on the next edge.
  - Out-of-range addresses (row >= ROWS or col >= COLS) are ignored.
  - A write on the swap edge lands in the pre-swap write bank, which becomes the display bank.
  - Writes never touch the display bank otherwise.
  - No copy is made on swap: the new write bank holds the previous display contents.
- Changes to the display row are visible only at the next SHOW latch. A row never changes mid-dwell.

Test Plan:
All scenarios use ROWS=8, COLS=8, DIV=10, BLANK=2, ACTIVE_LOW=1 unless stated.
1. Reset release:
   - Data_R/G/B = 8'hFF, COMM = 0, E = 0 for cycles 0-1.
   - E = 1 from cycle 2 with Data still 8'hFF.
   - COMM = 1 at cycle 10.
2. Scan timing:
   - COMM steps 0..7 every 10 cycles and wraps to 0.
   - frame_start pulses exactly every 80 cycles.
   - E is low for exactly 2 cycles per row.
3. Write and swap:
   - Write (row 3, col 0, rgb 3'b100), no swap: row 3 shows Data_R = 8'hFF.
   - Then pulse swap_req: swap_ack coincides with the next frame_start.
   - In the following frame, row 3 SHOW gives Data_R = 8'hFE, G/B = 8'hFF.
4. Multiple swap requests: swap_req pulsed three times within one frame -> exactly one swap_ack.
5. Write on the swap edge: write (row 5, col 7, 3'b011) on the swap_ack cycle -> the next frame row 5 shows Data_G = Data_B = 8'h7F.
6. Reset and polarity:
   - Assert RST mid-SHOW: E = 0 and Data = 8'hFF immediately, before any clock edge, and both banks read back blank.
   - Repeat with ACTIVE_LOW=0: inactive Data = 8'h00.
